// File: rtl/multi_channel_receive_queue.sv
// Per-channel fall-through receive FIFOs, round-robin arbitrated onto a single tagged mailbox stream.
// Optional build macro RECEIVE_QUEUE_STALL_COUNTERS_EN adds per-channel saturating stall counters.
//
// state     | meaning
// ST_OPEN   | grant chosen by round-robin scan from rr_ptr each cycle
// ST_LOCKED | offered entry was stalled; grant held in lock_ch until it pops
module multi_channel_receive_queue #(
  parameter int NUM_CHANNELS = 2,
  parameter int DEPTH        = 4,
  parameter int DATA_WIDTH   = 64,
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [NUM_CHANNELS-1:0]          in_valid,
  output logic [NUM_CHANNELS-1:0]          in_ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CH_W-1:0]                  out_channel,
  output logic [NUM_CHANNELS*CNT_W-1:0]    usage
`ifdef RECEIVE_QUEUE_STALL_COUNTERS_EN
  ,output logic [NUM_CHANNELS*16-1:0]      stall_count
`endif
);

  typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

  state_t                state, state_nxt;
  logic [CH_W-1:0]       lock_ch, lock_ch_nxt;
  logic [CH_W-1:0]       rr_ptr, rr_ptr_nxt;
  logic [CH_W-1:0]       grant;

  logic [DATA_WIDTH-1:0] mem    [NUM_CHANNELS][DEPTH];
  logic [PTR_W-1:0]      wr_ptr [NUM_CHANNELS];
  logic [PTR_W-1:0]      rd_ptr [NUM_CHANNELS];
  logic [CNT_W-1:0]      count  [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] head   [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] full, push, pop, cand;
  logic                    fire;

  // An empty channel exposes its incoming word directly so it can leave the same cycle.
  always_comb begin
    full     = '0;
    in_ready = '0;
    push     = '0;
    cand     = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      full[i]     = (count[i] == CNT_W'(DEPTH));
      in_ready[i] = ~full[i] & ~flush;
      push[i]     = in_valid[i] & in_ready[i];
      cand[i]     = (count[i] != '0) | push[i];
      head[i]     = (count[i] == '0) ? in_data[i*DATA_WIDTH +: DATA_WIDTH]
                                     : mem[i][rd_ptr[i]];
    end
  end

  always_comb begin : arb
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    if (state == ST_LOCKED) begin
      grant = lock_ch;
    end else begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
        if (!found && cand[idx]) begin
          found = 1'b1;
          grant = CH_W'(idx);
        end
      end
    end
  end

  always_comb begin
    out_valid   = (|cand) & ~flush;
    fire        = out_valid & out_ready;
    out_data    = out_valid ? head[grant] : '0;
    out_channel = out_valid ? grant : '0;
    pop         = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      pop[i] = fire & (grant == CH_W'(i));
    end
  end

  always_comb begin
    state_nxt   = state;
    lock_ch_nxt = lock_ch;
    rr_ptr_nxt  = rr_ptr;
    if (flush) begin
      state_nxt  = ST_OPEN;
      rr_ptr_nxt = '0;
    end else if (fire) begin
      state_nxt  = ST_OPEN;
      rr_ptr_nxt = (int'(grant) == NUM_CHANNELS - 1) ? '0 : grant + 1'b1;
    end else if (out_valid) begin
      state_nxt   = ST_LOCKED;
      lock_ch_nxt = grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_OPEN;
      lock_ch <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_ch_nxt;
      rr_ptr  <= rr_ptr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    usage = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      usage[i*CNT_W +: CNT_W] = count[i];
    end
  end

`ifdef RECEIVE_QUEUE_STALL_COUNTERS_EN
  // Flush does not clear these: they accumulate back-pressure history, including flush refusals.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (in_valid[i] & ~in_ready[i] & (stall_count[i*16 +: 16] != 16'hFFFF))
          stall_count[i*16 +: 16] <= stall_count[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multi_channel_receive_queue.sv
// Scoreboard bench for multi_channel_receive_queue: queue-based reference model plus decoupled output monitor.
module tb_multi_channel_receive_queue;
  localparam int NC    = 2;
  localparam int DEPTH = 4;
  localparam int DW    = 64;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [NC-1:0]    in_valid;
  logic [NC-1:0]    in_ready;
  logic [NC*DW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [0:0]       out_channel;
  logic [NC*CW-1:0] usage;
`ifdef RECEIVE_QUEUE_STALL_COUNTERS_EN
  logic [NC*16-1:0] stall_count;
`endif

  always #5 clk = ~clk;

  multi_channel_receive_queue #(.NUM_CHANNELS(NC), .DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_channel(out_channel), .usage(usage)
`ifdef RECEIVE_QUEUE_STALL_COUNTERS_EN
    , .stall_count(stall_count)
`endif
  );

  typedef struct {
    int          ch;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q [$];
  logic [DW-1:0] m_q [NC][$];
  int            m_rr;
  int            m_lock_ch;
  bit            m_locked;
  int            m_stall [NC];

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluated mid-cycle once inputs are settled, then advanced to the next cycle.
  always @(negedge clk) begin : model
    logic [NC-1:0] rdy, acc, cand;
    logic [DW-1:0] hd;
    int            g;
    bit            found, vld;
    rdy = '0; acc = '0; cand = '0; hd = '0; g = 0; found = 0; vld = 0;
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        m_q[c].delete();
        m_stall[c] = 0;
      end
      m_rr = 0; m_locked = 0; m_lock_ch = 0;
      chk("rst_in_ready", in_ready, {NC{1'b1}});
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_channel", out_channel, 0);
      chk("rst_usage", usage, 0);
`ifdef RECEIVE_QUEUE_STALL_COUNTERS_EN
      chk("rst_stall_count", stall_count, 0);
`endif
    end else begin
      for (int c = 0; c < NC; c++) begin
        rdy[c]  = (m_q[c].size() < DEPTH) && !flush;
        acc[c]  = in_valid[c] && rdy[c];
        cand[c] = (m_q[c].size() > 0) || acc[c];
      end
      if (m_locked) begin
        g = m_lock_ch;
      end else begin
        for (int k = 0; k < NC; k++) begin
          if (!found && cand[(m_rr + k) % NC]) begin
            found = 1;
            g = (m_rr + k) % NC;
          end
        end
      end
      vld = (cand != 0) && !flush;
      hd  = (m_q[g].size() > 0) ? m_q[g][0] : in_data[g*DW +: DW];

      chk("in_ready", in_ready, rdy);
      chk("out_valid", out_valid, vld);
      for (int c = 0; c < NC; c++) chk("usage", usage[c*CW +: CW], m_q[c].size());
      if (vld) begin
        chk("out_channel", out_channel, g);
        chk("out_data", out_data, hd);
      end else begin
        chk("idle_out_data", out_data, 0);
        chk("idle_out_channel", out_channel, 0);
      end
`ifdef RECEIVE_QUEUE_STALL_COUNTERS_EN
      for (int c = 0; c < NC; c++) chk("stall_count", stall_count[c*16 +: 16], m_stall[c]);
      for (int c = 0; c < NC; c++)
        if (in_valid[c] && !rdy[c] && m_stall[c] < 65535) m_stall[c]++;
`endif
      if (vld && out_ready) exp_q.push_back('{ch: g, data: hd});

      if (flush) begin
        for (int c = 0; c < NC; c++) m_q[c].delete();
        m_rr = 0; m_locked = 0;
      end else begin
        for (int c = 0; c < NC; c++)
          if (acc[c]) m_q[c].push_back(in_data[c*DW +: DW]);
        if (vld && out_ready) begin
          void'(m_q[g].pop_front());
          m_rr = (g + 1) % NC;
          m_locked = 0;
        end else if (vld) begin
          m_locked = 1;
          m_lock_ch = g;
        end
      end
    end
  end

  // Monitor: consumes one expected entry per accepted mailbox transfer.
  always @(negedge clk) begin : monitor
    exp_t e;
    #1;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_underflow: got ch %0d data %0h expected no transfer", out_channel, out_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_channel", out_channel, e.ch);
        chk("sb_data", out_data, e.data);
      end
    end
  end

  task automatic step(input logic [NC-1:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    in_valid        = v;
    in_data[0 +: DW]  = d0;
    in_data[DW +: DW] = d1;
    out_ready       = rdy;
    flush           = fl;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // fall-through on ch0
    step(2'b01, 64'hA5, 64'h0, 1'b1, 1'b0);
    #2;
    chk("ft_valid", out_valid, 1);
    chk("ft_data", out_data, 64'hA5);
    chk("ft_channel", out_channel, 0);
    step(2'b00, 0, 0, 1'b1, 1'b0);

    // fill ch1 to full, fifth push refused, then drain in order
    for (int i = 1; i <= 5; i++) step(2'b10, 0, i, 1'b0, 1'b0);
    repeat (5) step(2'b00, 0, 0, 1'b1, 1'b0);

    // round-robin interleave
    step(2'b11, 10, 20, 1'b0, 1'b0);
    step(2'b11, 11, 21, 1'b0, 1'b0);
    repeat (5) step(2'b00, 0, 0, 1'b1, 1'b0);

    // lock held over three stalled cycles
    step(2'b11, 30, 40, 1'b0, 1'b0);
    repeat (2) step(2'b00, 0, 0, 1'b0, 1'b0);
    repeat (3) step(2'b00, 0, 0, 1'b1, 1'b0);

    // flush with both channels at three entries and lock active
    for (int i = 0; i < 3; i++) step(2'b11, 50 + i, 60 + i, 1'b0, 1'b0);
    step(2'b11, 64'h99, 64'h99, 1'b1, 1'b1);
    repeat (2) step(2'b00, 0, 0, 1'b1, 1'b0);

    // hold ch0 full under back-pressure
    for (int i = 0; i < 9; i++) step(2'b01, 70 + i, 0, 1'b0, 1'b0);
    step(2'b00, 0, 0, 1'b0, 1'b1);
    repeat (2) step(2'b00, 0, 0, 1'b1, 1'b0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(NC'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
           ($urandom_range(0, 99) < 55), ($urandom_range(0, 59) == 0));
    end
    repeat (12) step(2'b00, 0, 0, 1'b1, 1'b0);

    // mid-run reset
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) step(2'b00, 0, 0, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    chk("sb_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
